// File: rtl/seq_chunk_adder.sv
// Multi-cycle wide adder that walks a CHUNK-bit add slice over WIDTH-bit operands, LSB chunk first.
// Define SEQ_CHUNK_ADDER_SUB_EN to make the sub port select a two's-complement subtraction.
module seq_chunk_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             busy
);

   localparam int N    = WIDTH / CHUNK;
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_beff;
   logic [WIDTH-1:0] r_s;
   logic [IDXW-1:0]  r_idx;
   logic             r_carry;
   logic             r_cout;

   logic [WIDTH-1:0] w_beff;
   logic             w_cin;
   logic [CHUNK-1:0] w_a_chunk;
   logic [CHUNK-1:0] w_b_chunk;
   logic [CHUNK:0]   w_sum;
   logic             w_last;

`ifdef SEQ_CHUNK_ADDER_SUB_EN
   assign w_beff = sub ? ~b : b;
   assign w_cin  = sub;
`else
   // The sub port is kept for a uniform interface; masking it here keeps it connected but inert.
   assign w_beff = b;
   assign w_cin  = sub & 1'b0;
`endif

   assign w_a_chunk = r_a[int'(r_idx)*CHUNK +: CHUNK];
   assign w_b_chunk = r_beff[int'(r_idx)*CHUNK +: CHUNK];
   assign w_sum     = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + (CHUNK+1)'(r_carry);
   assign w_last    = (r_idx == IDXW'(N - 1));

   // Handshake flags decode the state register only, so no input reaches them combinationally.
   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign busy      = (r_state != ST_IDLE);
   assign s         = r_s;
   assign cout      = r_cout;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_s     <= '0;
         r_cout  <= 1'b0;
         r_a     <= '0;
         r_beff  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_beff  <= w_beff;
                  r_s     <= '0;
                  r_carry <= w_cin;
                  r_idx   <= '0;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               r_s[int'(r_idx)*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
               r_carry                         <= w_sum[CHUNK];
               if (w_last) begin
                  // idx stays on the last chunk so it never leaves 0..N-1 (N==1 included).
                  r_cout  <= w_sum[CHUNK];
                  r_state <= ST_DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder at WIDTH=8, CHUNK=2 (four chunk steps per operation).
// Subtraction expectations follow whether SEQ_CHUNK_ADDER_SUB_EN is defined for the build.
module tb_seq_chunk_adder;

   localparam int WIDTH = 8;
   localparam int CHUNK = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             busy;

   int n_checks = 0;
   int n_errors = 0;

   seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .cout      (cout),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just past it for driving and sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Accept one operand pair and wait (bounded) for out_valid; returns cycles from accept.
   task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b, input logic op_sub,
                         output int lat);
      a        = op_a;
      b        = op_b;
      sub      = op_sub;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("accept_clears_s", 32'(s), 32'h0);
      check("accept_busy", 32'(busy), 32'h1);
      check("accept_in_ready", 32'(in_ready), 32'h0);
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (out_valid) begin
            lat = i;
            break;
         end
      end
   endtask

   int  lat;
   logic saw_valid;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      sub       = 1'b0;

      // Reset then idle
      step();
      step();
      rst_n = 1'b1;
      check("rst_in_ready", 32'(in_ready), 32'h1);
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_s", 32'(s), 32'h0);
      check("rst_cout", 32'(cout), 32'h0);

      // 0x5A + 0x3C = 0x96, no carry
      out_ready = 1'b1;
      run_op(8'h5A, 8'h3C, 1'b0, lat);
      check("add1_latency", 32'(lat), 32'd4);
      check("add1_s", 32'(s), 32'h96);
      check("add1_cout", 32'(cout), 32'h0);
      step();
      check("add1_in_ready_after", 32'(in_ready), 32'h1);
      check("add1_out_valid_after", 32'(out_valid), 32'h0);
      check("add1_s_held_idle", 32'(s), 32'h96);

      // 0xFF + 0x01 = 0x100: carry ripples through every chunk
      run_op(8'hFF, 8'h01, 1'b0, lat);
      check("add2_latency", 32'(lat), 32'd4);
      check("add2_s", 32'(s), 32'h00);
      check("add2_cout", 32'(cout), 32'h1);
      step();

      // Backpressure: result held, new operands ignored while DONE
      out_ready = 1'b0;
      run_op(8'h12, 8'h34, 1'b0, lat);
      check("bp_latency", 32'(lat), 32'd4);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            a        = 8'hFF;
            b        = 8'hFF;
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         step();
         check("bp_out_valid", 32'(out_valid), 32'h1);
         check("bp_s", 32'(s), 32'h46);
         check("bp_in_ready", 32'(in_ready), 32'h0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      check("bp_hs_out_valid", 32'(out_valid), 32'h0);
      check("bp_hs_in_ready", 32'(in_ready), 32'h1);
      check("bp_hs_s", 32'(s), 32'h46);
      step();
      check("bp_not_queued", 32'(busy), 32'h0);

      // Reset during the second RUN cycle discards the partial result
      a        = 8'hAA;
      b        = 8'h55;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      check("mid_busy_before_rst", 32'(busy), 32'h1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("mid_rst_in_ready", 32'(in_ready), 32'h1);
      check("mid_rst_busy", 32'(busy), 32'h0);
      check("mid_rst_out_valid", 32'(out_valid), 32'h0);
      check("mid_rst_s", 32'(s), 32'h0);
      saw_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (out_valid) saw_valid = 1'b1;
      end
      check("mid_rst_no_valid", 32'(saw_valid), 32'h0);
      run_op(8'h01, 8'h01, 1'b0, lat);
      check("post_rst_latency", 32'(lat), 32'd4);
      check("post_rst_s", 32'(s), 32'h02);
      step();

`ifdef SEQ_CHUNK_ADDER_SUB_EN
      run_op(8'h10, 8'h01, 1'b1, lat);
      check("sub1_s", 32'(s), 32'h0F);
      check("sub1_cout", 32'(cout), 32'h1);
      step();
      run_op(8'h01, 8'h02, 1'b1, lat);
      check("sub2_s", 32'(s), 32'hFF);
      check("sub2_cout", 32'(cout), 32'h0);
      step();
`else
      run_op(8'h10, 8'h01, 1'b1, lat);
      check("sub_ignored_s", 32'(s), 32'h11);
      check("sub_ignored_cout", 32'(cout), 32'h0);
      step();
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
